// File: rtl/reg_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sequencer_pkg
// Brief    : Opcodes, FSM encoding, APU register indices and mute table
//            shared by the song sequencer.
// Revision : 1.0
// ============================================================================
package reg_write_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_WAIT  = 2'b01,
    OP_JUMP  = 2'b10,
    OP_END   = 2'b11
  } opcode_e;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_MUTE  = 3'd4;

  localparam logic [3:0] REG_4000 = 4'h0;
  localparam logic [3:0] REG_4001 = 4'h1;
  localparam logic [3:0] REG_4002 = 4'h2;
  localparam logic [3:0] REG_4003 = 4'h3;
  localparam logic [3:0] REG_4004 = 4'h4;
  localparam logic [3:0] REG_4005 = 4'h5;
  localparam logic [3:0] REG_4006 = 4'h6;
  localparam logic [3:0] REG_4007 = 4'h7;
  localparam logic [3:0] REG_4008 = 4'h8;
  localparam logic [3:0] REG_4009 = 4'h9;
  localparam logic [3:0] REG_400A = 4'hA;
  localparam logic [3:0] REG_400B = 4'hB;
  localparam logic [3:0] REG_400C = 4'hC;
  localparam logic [3:0] REG_400D = 4'hD;
  localparam logic [3:0] REG_400E = 4'hE;
  localparam logic [3:0] REG_400F = 4'hF;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } reg_wr_t;

  localparam int MUTE_LEN = 4;

  // Silences both pulse channels, the triangle linear counter and noise.
  function automatic reg_wr_t mute_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    mute_entry = '{addr: REG_4000, data: 8'h30};
      2'd1:    mute_entry = '{addr: REG_4004, data: 8'h30};
      2'd2:    mute_entry = '{addr: REG_4008, data: 8'h00};
      default: mute_entry = '{addr: REG_400C, data: 8'h30};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sequencer_if
// Brief    : UART write request, program ROM port and register write port
//            of the song sequencer. master = sequencer side.
// Revision : 1.0
// ============================================================================
interface reg_write_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              uart_valid;
  logic [3:0]        uart_addr;
  logic [7:0]        uart_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  uart_valid, uart_addr, uart_data, rom_data,
    output rom_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output uart_valid, uart_addr, uart_data, rom_data,
    input  rom_addr, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sequencer
// Brief    : Autonomous song player; fetches ROM commands and arbitrates the
//            APU register write port with the UART path (UART wins).
//            Option macro SEQ_MUTE_EN: mute writes on END/stop/runaway.
// Revision : 1.0
// ============================================================================
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_OPS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  reg_write_sequencer_if.master bus,
  output logic                  playing,
  output logic                  error
);

  localparam int               OPS_W    = $clog2(MAX_OPS + 1);
  localparam logic [OPS_W-1:0] OPS_LAST = OPS_W'(MAX_OPS - 1);
`ifdef SEQ_MUTE_EN
  localparam state_t ST_STOP = ST_MUTE;
`else
  localparam state_t ST_STOP = ST_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_wait_cnt;
  logic [OPS_W-1:0]  r_op_cnt;
  logic              r_error;
  logic              r_wr_en;
  logic [3:0]        r_wr_addr;
  logic [7:0]        r_wr_data;

  logic              w_wr_req;
  logic [3:0]        w_wr_addr;
  logic [7:0]        w_wr_data;

  opcode_e           w_op;
  logic [3:0]        w_cmd_addr;
  logic [7:0]        w_cmd_data;
  logic [ADDR_W-1:0] w_jump_pc;
  logic              w_in_mute;
  logic              w_halt;
  logic              w_restart;
  logic              w_blocked;
  logic              w_runaway;
  logic              w_done;
  logic              w_unused;

  assign w_op       = opcode_e'(bus.rom_data[15:14]);
  assign w_cmd_addr = bus.rom_data[11:8];
  assign w_cmd_data = bus.rom_data[7:0];
  assign w_jump_pc  = bus.rom_data[ADDR_W-1:0];
  assign w_unused   = ^bus.rom_data[13:12];

`ifdef SEQ_MUTE_EN
  logic [1:0] r_mute_idx;
  assign w_in_mute = (r_state == ST_MUTE);
`else
  assign w_in_mute = 1'b0;
`endif

  // stop outranks start; both are ignored while the mute sequence drains
  assign w_halt    = stop && (r_state != ST_IDLE) && !w_in_mute;
  assign w_restart = start && !stop && !w_in_mute;
  assign w_blocked = (r_state == ST_EXEC) && (w_op == OP_WRITE) && bus.uart_valid;
  assign w_runaway = !tick && (r_op_cnt == OPS_LAST);
  assign w_done    = (r_state == ST_EXEC) && !w_blocked && !w_halt && !w_restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_halt) begin
      w_state_nxt = ST_STOP;
    end else if (w_restart) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_FETCH: w_state_nxt = ST_EXEC;
        ST_EXEC: begin
          if (w_done) begin
            if (w_runaway) begin
              w_state_nxt = ST_STOP;
            end else begin
              case (w_op)
                OP_WAIT: w_state_nxt = (w_cmd_data == 8'd0) ? ST_FETCH : ST_WAIT;
                OP_END:  w_state_nxt = ST_STOP;
                default: w_state_nxt = ST_FETCH;
              endcase
            end
          end
        end
        ST_WAIT: begin
          if (tick && (r_wait_cnt <= 8'd1)) w_state_nxt = ST_FETCH;
        end
`ifdef SEQ_MUTE_EN
        ST_MUTE: begin
          if (!bus.uart_valid && (r_mute_idx == 2'(MUTE_LEN - 1))) w_state_nxt = ST_IDLE;
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    playing   = (r_state != ST_IDLE);
    w_wr_req  = 1'b0;
    w_wr_addr = 4'h0;
    w_wr_data = 8'h00;
    if (bus.uart_valid) begin
      w_wr_req  = 1'b1;
      w_wr_addr = bus.uart_addr;
      w_wr_data = bus.uart_data;
    end else if (w_done && !w_runaway && (w_op == OP_WRITE)) begin
      w_wr_req  = 1'b1;
      w_wr_addr = w_cmd_addr;
      w_wr_data = w_cmd_data;
    end
`ifdef SEQ_MUTE_EN
    else if (w_in_mute) begin
      w_wr_req               = 1'b1;
      {w_wr_addr, w_wr_data} = mute_entry(r_mute_idx);
    end
`endif
  end

`ifdef SEQ_MUTE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_mute_idx <= 2'd0;
    else if (!w_in_mute)     r_mute_idx <= 2'd0;
    else if (!bus.uart_valid) r_mute_idx <= r_mute_idx + 2'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_wait_cnt <= 8'd0;
      r_op_cnt   <= '0;
      r_error    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 4'h0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_en   <= w_wr_req;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      if (w_restart) begin
        r_pc       <= '0;
        r_wait_cnt <= 8'd0;
        r_op_cnt   <= '0;
        r_error    <= 1'b0;
      end else begin
        if (w_done && !w_runaway) begin
          case (w_op)
            OP_WRITE: r_pc <= r_pc + 1'b1;
            OP_WAIT: begin
              r_pc       <= r_pc + 1'b1;
              r_wait_cnt <= w_cmd_data;
            end
            OP_JUMP:  r_pc <= w_jump_pc;
            default:  r_pc <= r_pc;
          endcase
        end else if ((r_state == ST_WAIT) && tick && (r_wait_cnt != 8'd0)) begin
          r_wait_cnt <= r_wait_cnt - 8'd1;
        end
        if (tick)        r_op_cnt <= '0;
        else if (w_done) r_op_cnt <= r_op_cnt + 1'b1;
        if (w_done && w_runaway) r_error <= 1'b1;
      end
    end
  end

  assign bus.rom_addr = r_pc;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_sequencer
// Brief    : Randomized self-checking bench with a command-level song model.
// Revision : 1.0
// ============================================================================
module tb_reg_write_sequencer;
  localparam int          ADDR_W  = 8;
  localparam int          MAX_OPS = 64;
  localparam logic [15:0] CMD_END = 16'hC000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic playing;
  logic error;

  reg_write_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  reg_write_sequencer #(.ADDR_W(ADDR_W), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .bus(bus), .playing(playing), .error(error)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct packed { logic [3:0] a; logic [7:0] d; int cyc; } wr_t;
  wr_t         wq[$];
  logic [11:0] exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.wr_en === 1'b1) wq.push_back('{a: bus.wr_addr, d: bus.wr_data, cyc: cyc});

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd_pulse(input logic s, input logic p);
    start = s; stop = p; step(); start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (playing === 1'b0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = CMD_END;
  endtask

  // Song-level interpreter: no ticks, WAIT only with n=0.
  function automatic void model_program();
    int pc; int ops; logic [15:0] c; logic fin;
    pc = 0; ops = 0; fin = 1'b0;
    exp_q.delete();
    while (!fin && ops < MAX_OPS) begin
      c = rom[pc];
      ops++;
      case (c[15:14])
        2'b00:   begin exp_q.push_back(c[11:0]); pc = (pc + 1) % 256; end
        2'b01:   pc = (pc + 1) % 256;
        2'b10:   pc = int'(c[7:0]);
        default: fin = 1'b1;
      endcase
    end
`ifdef SEQ_MUTE_EN
    exp_q.push_back(12'h030); exp_q.push_back(12'h430);
    exp_q.push_back(12'h800); exp_q.push_back(12'hC30);
`endif
  endfunction

  task automatic compare_writes(input string name);
    total++;
    if (wq.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", name, wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      total++;
      if ({wq[i].a, wq[i].d} !== exp_q[i]) begin
        bad++; $display("FAIL %s_wr%0d got=%h exp=%h", name, i, {wq[i].a, wq[i].d}, exp_q[i]);
      end
    end
  endtask

  task automatic finish_song(input string name);
    logic ok;
    wait_idle(600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_idle got=playing exp=idle", name); end
    step(3);
  endtask

  task automatic test_reset();
    logic ok;
    total++;
    if ({bus.wr_en, bus.rom_addr, playing, error} !== '0) begin
      bad++; $display("FAIL rst_init got=%h exp=0", {bus.wr_en, bus.rom_addr, playing, error});
    end
    reset = 1'b0; step(2);
    clear_rom();
    rom[0] = 16'h4005; rom[1] = 16'h0E55;
    wq.delete();
    cmd_pulse(1'b1, 1'b0);
    step(4);
    bus.uart_valid = 1'b1; bus.uart_addr = 4'h9; bus.uart_data = 8'hA5;
    reset = 1'b1; #2;
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== '0) begin
      bad++; $display("FAIL rst_mid_wr got=%h exp=0", {bus.wr_en, bus.wr_addr, bus.wr_data});
    end
    total++;
    if (bus.rom_addr !== 8'h00) begin bad++; $display("FAIL rst_mid_pc got=%h exp=00", bus.rom_addr); end
    total++;
    if ({playing, error} !== 2'b00) begin bad++; $display("FAIL rst_mid_flags got=%b exp=00", {playing, error}); end
    step();
    bus.uart_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin tick = 1'b1; step(); tick = 1'b0; step(3); end
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL rst_no_write got=%0d exp=0", wq.size()); end
    total++;
    if (playing !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", playing); end
    wait_idle(5, ok);
  endtask

  task automatic test_write_programs();
    int len; int k0;
    for (int r = 0; r < 6; r++) begin
      clear_rom();
      if (r == 0) begin
        rom[0] = 16'h02FD; rom[1] = 16'h0308;
      end else begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
          case ($urandom_range(0, 3))
            0, 1:    rom[i] = {2'b00, 2'($urandom), 4'($urandom), 8'($urandom)};
            2:       rom[i] = {2'b01, 2'($urandom), 4'($urandom), 8'h00};
            default: rom[i] = {2'b10, 6'($urandom), 8'($urandom_range(i + 1, len))};
          endcase
        end
      end
      model_program();
      wq.delete();
      cmd_pulse(1'b1, 1'b0);
      k0 = cyc;
      finish_song("prog");
      compare_writes("prog");
      if (r == 0) begin
        total++;
        if (wq.size() == 0 || wq[0].cyc != k0 + 2) begin
          bad++; $display("FAIL prog_latency got=%0d exp=%0d", (wq.size() == 0) ? -1 : wq[0].cyc - k0, 2);
        end
      end
      total++;
      if (error !== 1'b0) begin bad++; $display("FAIL prog_error got=%b exp=0", error); end
    end
  endtask

  task automatic test_wait();
    int n; int t_last; int k0; logic [7:0] d;
    clear_rom();
    n = $urandom_range(1, 4);
    rom[0] = {8'h40, 8'(n)}; rom[1] = 16'h00BF;
    wq.delete();
    cmd_pulse(1'b1, 1'b0);
    step(4);
    t_last = 0;
    for (int t = 1; t <= n; t++) begin
      step($urandom_range(2, 6));
      if (t == n) begin
        total++;
        if (wq.size() != 0) begin bad++; $display("FAIL wait_early got=%0d exp=0", wq.size()); end
      end
      tick = 1'b1; step(); tick = 1'b0;
      t_last = cyc;
    end
    step(6);
    total++;
    if (wq.size() == 0 || {wq[0].a, wq[0].d, wq[0].cyc} !== {12'h0BF, t_last + 2}) begin
      bad++; $display("FAIL wait_n got_cyc=%0d exp_cyc=%0d", (wq.size() == 0) ? -1 : wq[0].cyc, t_last + 2);
    end
    finish_song("wait_n");

    clear_rom();
    d = 8'($urandom);
    rom[0] = 16'h4000; rom[1] = {8'h07, d};
    wq.delete();
    cmd_pulse(1'b1, 1'b0);
    k0 = cyc;
    finish_song("wait0");
    total++;
    if (wq.size() == 0 || {wq[0].a, wq[0].d} !== {4'h7, d} || wq[0].cyc != k0 + 4) begin
      bad++; $display("FAIL wait0 got_cyc=%0d exp_cyc=%0d", (wq.size() == 0) ? -1 : wq[0].cyc, k0 + 4);
    end
  endtask

  task automatic test_collision();
    int k0; logic [3:0] ua, sa; logic [7:0] ud, sd;
    for (int r = 0; r < 4; r++) begin
      ua = (r == 0) ? 4'h5 : 4'($urandom); ud = (r == 0) ? 8'h7F : 8'($urandom);
      sa = (r == 0) ? 4'h1 : 4'($urandom); sd = (r == 0) ? 8'h08 : 8'($urandom);
      clear_rom();
      rom[0] = {4'h0, sa, sd};
      model_program();
      exp_q.push_front({ua, ud});
      wq.delete();
      cmd_pulse(1'b1, 1'b0);
      k0 = cyc;
      step();
      bus.uart_valid = 1'b1; bus.uart_addr = ua; bus.uart_data = ud;
      step();
      bus.uart_valid = 1'b0;
      finish_song("coll");
      compare_writes("coll");
      total++;
      if (wq.size() < 2 || wq[0].cyc != k0 + 2 || wq[1].cyc != k0 + 3) begin
        bad++; $display("FAIL coll_timing got=%0d exp=%0d", (wq.size() < 2) ? -1 : wq[1].cyc - k0, 3);
      end
    end
    wq.delete();
    ud = 8'($urandom);
    bus.uart_valid = 1'b1; bus.uart_addr = 4'hB; bus.uart_data = ud;
    step();
    bus.uart_valid = 1'b0;
    k0 = cyc;
    step(3);
    total++;
    if (wq.size() != 1 || {wq[0].a, wq[0].d} !== {4'hB, ud} || wq[0].cyc != k0) begin
      bad++; $display("FAIL uart_idle got=%0d exp=1", wq.size());
    end
  endtask

  task automatic test_runaway();
    logic ok;
    clear_rom();
    rom[0] = 16'h8000;
    model_program();
    wq.delete();
    cmd_pulse(1'b1, 1'b0);
    step(127);
    total++;
    if ({error, playing} !== 2'b01) begin bad++; $display("FAIL run_early got=%b exp=01", {error, playing}); end
    step();
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL run_error got=%b exp=1", error); end
    finish_song("run");
    compare_writes("run");
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL run_sticky got=%b exp=1", error); end
    cmd_pulse(1'b1, 1'b0);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL run_clear got=%b exp=0", error); end
    for (int i = 0; i < 300; i++) begin tick = ((i % 40) == 39); step(); end
    tick = 1'b0;
    total++;
    if ({error, playing} !== 2'b01) begin bad++; $display("FAIL run_ticked got=%b exp=01", {error, playing}); end
    cmd_pulse(1'b0, 1'b1);
    wait_idle(50, ok);
    step(3);
  endtask

  task automatic test_wrap_startstop();
    logic [3:0] a; logic [7:0] d; logic ok;
    clear_rom();
    a = 4'($urandom); d = 8'($urandom);
    rom[0] = 16'h80FF; rom[255] = {4'h0, a, d};
    wq.delete();
    cmd_pulse(1'b1, 1'b0);
    step(2);
    total++;
    if (bus.rom_addr !== 8'hFF) begin bad++; $display("FAIL wrap_jump got=%h exp=ff", bus.rom_addr); end
    step(2);
    total++;
    if ({bus.rom_addr, bus.wr_en, bus.wr_addr, bus.wr_data} !== {8'h00, 1'b1, a, d}) begin
      bad++; $display("FAIL wrap_pc got=%h exp=%h", {bus.rom_addr, bus.wr_en, bus.wr_addr, bus.wr_data}, {8'h00, 1'b1, a, d});
    end
    cmd_pulse(1'b1, 1'b1);
`ifndef SEQ_MUTE_EN
    total++;
    if (playing !== 1'b0) begin bad++; $display("FAIL startstop_idle got=%b exp=0", playing); end
`endif
    wait_idle(50, ok);
    step(3);
    wq.delete();
    cmd_pulse(1'b1, 1'b1);
    step(4);
    total++;
    if ({playing, wq.size() == 0} !== 2'b01) begin
      bad++; $display("FAIL startstop_from_idle got=%b exp=01", {playing, wq.size() == 0});
    end
  endtask

  initial begin
    bus.uart_valid = 1'b0; bus.uart_addr = 4'h0; bus.uart_data = 8'h00;
    clear_rom();
    step(3);
    test_reset();
    test_write_programs();
    test_wait();
    test_collision();
    test_runaway();
    test_wrap_startstop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
